alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Executes the existing LEGv8 logic/arithmetic ops in one cycle. Adds iterative multiply (MUL, UMULH) and divide (UDIV, SDIV).
- Produces NZCV flags and uses a start/done handshake so the control unit can stall on long ops.
- Sits in the execute stage between the register-file/immediate mux and the data-memory/writeback path.

Parameters:
- N, 64: operand and result width in bits; must be even and >= 4.
- CW, 4: width of ALUControl.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  N  operand A (rn)
- b  input  N  operand B (rm or immediate)
- ALUControl  input  CW  operation select
- ready  output  1  block can accept start this cycle
- busy  output  1  iterative op in progress
- done  output  1  one-cycle pulse: result and flags valid
- result  output  N  registered result, held until next accepted start
- zero  output  1  result == 0
- negative  output  1  result[N-1]
- carry  output  1  carry out (ADD), not-borrow (SUB), else 0
- overflow  output  1  signed overflow (ADD/SUB), else 0

Behaviour:
- Reset is asynchronous and active-high; clock is the single domain clk. Reset values: result=0, zero=1, negative=0, carry=0, overflow=0, done=0, busy=0, ready=1, FSM=IDLE, iteration counter=0.
- ALUControl encoding:
  - 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (a-b); 0111 PASSB; 1100 NOR.
  - 1000 MUL (low N bits of a*b); 1001 UMULH (high N bits of unsigned a*b).
  - 1010 UDIV; 1011 SDIV (truncate toward zero).
  - Any other code behaves as PASSB; flags per PASSB.
- FSM states: IDLE, MUL, DIV, SFIX.
- IDLE, start=1:
  - a, b and op are latched at that edge.
  - Single-cycle op: result and flags registered at the same edge; done=1 in the next cycle; FSM stays IDLE.
  - MUL/UMULH go to MUL; UDIV/SDIV go to DIV; counter loaded with N.
- MUL: one shift-add per cycle on a 2N-bit product register. Counter decrements; when it reaches 0, result is the low half (MUL) or high half (UMULH); done=1; next state IDLE.
- DIV: one restoring-division step per cycle on operand magnitudes (SDIV converts to magnitudes at latch).
  - UDIV goes to IDLE at count 0.
  - SDIV goes to SFIX, which negates the quotient when sign(a)!=sign(b), then IDLE.
- Latency from the accepting edge to done high:
  - 1 cycle for single-cycle ops.
  - N+1 cycles for MUL, UMULH, UDIV.
  - N+2 cycles for SDIV.
- busy=1 exactly while FSM != IDLE; ready = !busy.
- done is high for exactly one cycle, and that cycle has busy=0, so a start in the done cycle is accepted (back-to-back).
- start while busy is ignored; there is no queueing.
- Operand inputs may change after the accepting edge without effect.
- Divide by zero (UDIV/SDIV with b=0): result=0, standard latency, no trap.
- SDIV with a = most-negative and b = -1: result = most-negative (wraps); overflow stays 0.
- Flags:
  - zero and negative are updated for every op.
  - carry and overflow are computed only for ADD/SUB and are 0 for all other ops.
  - SUB carry = 1 when a >= b unsigned.
- Reset asserted mid-operation aborts immediately to reset values; no done is produced for the aborted op.
- result and flags change only on done cycles or reset.

Test Plan:
- Reset, then ADD, N=64: a=5, b=7 -> done 1 cycle later, result=12, zero=0, carry=0, overflow=0; busy never high.
- SUB, N=64: a=b=0x8000000000000000 -> result=0, zero=1, carry=1. Then ADD a=0x7FFFFFFFFFFFFFFF, b=1 -> negative=1, overflow=1.
- MUL then UMULH, N=64: a=b=0xFFFFFFFFFFFFFFFF.
  - MUL: busy high 64 cycles, done at cycle 65, result=1.
  - UMULH, issued back-to-back in the done cycle: result=0xFFFFFFFFFFFFFFFE.
- SDIV, N=8:
  - a=-7 (0xF9), b=2 -> done at cycle 10, result=0xFD (-3).
  - a=0x80, b=0xFF -> result=0x80.
  - UDIV a=9, b=0 -> result=0, zero=1.
- Handshake: start pulsed again at cycles 3 and 20 during a 64-bit UDIV 100/7 -> both ignored; single done; result=14.
- Reset asserted at cycle 30 of a MUL -> outputs at reset values asynchronously, no done. Subsequent OR a=0xF0, b=0x0F -> result=0xFF.

Source files
------------

// File: rtl/alu_multicycle.sv
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Registered LEGv8 ALU with NZCV flags, iterative MUL/UMULH/UDIV/SDIV
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multicycle #(
  parameter int N  = 64,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [CW-1:0] ALUControl,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          zero,
  output logic          negative,
  output logic          carry,
  output logic          overflow
);

  localparam int CNTW = $clog2(N + 1);

  localparam logic [CW-1:0] OP_AND   = CW'(4'b0000);
  localparam logic [CW-1:0] OP_ORR   = CW'(4'b0001);
  localparam logic [CW-1:0] OP_ADD   = CW'(4'b0010);
  localparam logic [CW-1:0] OP_SUB   = CW'(4'b0110);
  localparam logic [CW-1:0] OP_NOR   = CW'(4'b1100);
  localparam logic [CW-1:0] OP_MUL   = CW'(4'b1000);
  localparam logic [CW-1:0] OP_UMULH = CW'(4'b1001);
  localparam logic [CW-1:0] OP_UDIV  = CW'(4'b1010);
  localparam logic [CW-1:0] OP_SDIV  = CW'(4'b1011);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_SFIX = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    opnd_q, opnd_d;
  logic            hi_q, hi_d;
  logic            sdiv_q, sdiv_d;
  logic            neg_q, neg_d;
  logic            bzero_q, bzero_d;
  logic [N-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            negative_q, negative_d;
  logic            carry_q, carry_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  logic            w_fin;
  logic [N-1:0]    w_fin_res;
  logic            w_fin_c;
  logic            w_fin_v;

  // Shift-add step: product register holds {partial high, remaining multiplier}.
  logic [N:0]      w_mul_sum;
  logic [2*N-1:0]  w_mul_next;
  assign w_mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[N-1:1]};

  // Restoring-division step: accumulator holds {remainder, dividend/quotient}.
  logic [N:0]      w_rem_sh;
  logic [N:0]      w_rem_diff;
  logic [2*N-1:0]  w_div_next;
  assign w_rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, opnd_q};
  assign w_div_next = w_rem_diff[N] ? {w_rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                                    : {w_rem_diff[N-1:0], acc_q[N-2:0], 1'b1};

  logic [N:0]      w_add;
  logic [N:0]      w_sub;
  logic [N-1:0]    w_a_mag;
  logic [N-1:0]    w_b_mag;
  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
  assign w_a_mag = a[N-1] ? -a : a;
  assign w_b_mag = b[N-1] ? -b : b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= 1'b0;
      sdiv_q     <= 1'b0;
      neg_q      <= 1'b0;
      bzero_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      sdiv_q     <= sdiv_d;
      neg_q      <= neg_d;
      bzero_q    <= bzero_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    sdiv_d     = sdiv_q;
    neg_d      = neg_q;
    bzero_d    = bzero_q;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    w_fin      = 1'b0;
    w_fin_res  = '0;
    w_fin_c    = 1'b0;
    w_fin_v    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (ALUControl)
            OP_MUL, OP_UMULH: begin
              state_d = S_MUL;
              cnt_d   = CNTW'(N);
              acc_d   = {{N{1'b0}}, b};
              opnd_d  = a;
              hi_d    = (ALUControl == OP_UMULH);
            end
            OP_UDIV, OP_SDIV: begin
              state_d = S_DIV;
              cnt_d   = CNTW'(N);
              sdiv_d  = (ALUControl == OP_SDIV);
              bzero_d = (b == '0);
              if (ALUControl == OP_SDIV) begin
                acc_d  = {{N{1'b0}}, w_a_mag};
                opnd_d = w_b_mag;
                neg_d  = a[N-1] ^ b[N-1];
              end else begin
                acc_d  = {{N{1'b0}}, a};
                opnd_d = b;
                neg_d  = 1'b0;
              end
            end
            OP_AND: begin
              w_fin     = 1'b1;
              w_fin_res = a & b;
            end
            OP_ORR: begin
              w_fin     = 1'b1;
              w_fin_res = a | b;
            end
            OP_NOR: begin
              w_fin     = 1'b1;
              w_fin_res = ~(a | b);
            end
            OP_ADD: begin
              w_fin     = 1'b1;
              w_fin_res = w_add[N-1:0];
              w_fin_c   = w_add[N];
              w_fin_v   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
            end
            OP_SUB: begin
              w_fin     = 1'b1;
              w_fin_res = w_sub[N-1:0];
              w_fin_c   = w_sub[N];
              w_fin_v   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
            end
            default: begin
              w_fin     = 1'b1;
              w_fin_res = b;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = w_mul_next;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d   = S_IDLE;
          w_fin     = 1'b1;
          w_fin_res = hi_q ? w_mul_next[2*N-1:N] : w_mul_next[N-1:0];
        end
      end
      S_DIV: begin
        acc_d = w_div_next;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          if (sdiv_q) begin
            state_d = S_SFIX;
          end else begin
            state_d   = S_IDLE;
            w_fin     = 1'b1;
            w_fin_res = bzero_q ? '0 : w_div_next[N-1:0];
          end
        end
      end
      default: begin
        // Most-negative / -1 wraps naturally: the magnitude quotient negates to itself.
        state_d   = S_IDLE;
        w_fin     = 1'b1;
        w_fin_res = bzero_q ? '0 : (neg_q ? -acc_q[N-1:0] : acc_q[N-1:0]);
      end
    endcase

    if (w_fin) begin
      result_d   = w_fin_res;
      zero_d     = (w_fin_res == '0);
      negative_d = w_fin_res[N-1];
      carry_d    = w_fin_c;
      overflow_d = w_fin_v;
      done_d     = 1'b1;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign ready    = ~busy;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Directed self-checking bench for alu_multicycle (N=64 and N=8)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        s64;
  logic [63:0] a64, b64;
  logic [3:0]  op64;
  logic        rdy64, bsy64, dn64, z64, n64, c64, v64;
  logic [63:0] r64;

  logic        s8;
  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic        rdy8, bsy8, dn8, z8, n8, c8, v8;
  logic [7:0]  r8;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.N(64), .CW(4)) u_dut64 (
    .clk(clk), .reset(reset), .start(s64), .a(a64), .b(b64), .ALUControl(op64),
    .ready(rdy64), .busy(bsy64), .done(dn64), .result(r64),
    .zero(z64), .negative(n64), .carry(c64), .overflow(v64)
  );

  alu_multicycle #(.N(8), .CW(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8), .ALUControl(op8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .result(r8),
    .zero(z8), .negative(n8), .carry(c8), .overflow(v8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go64(input logic [3:0] op, input logic [63:0] ia, input logic [63:0] ib);
    op64 = op; a64 = ia; b64 = ib; s64 = 1'b1;
    tick();
    s64 = 1'b0;
  endtask

  task automatic go8(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib);
    op8 = op; a8 = ia; b8 = ib; s8 = 1'b1;
    tick();
    s8 = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after the accepting edge) in which done is seen.
  task automatic wait64(output int cyc, output int nb);
    cyc = 1; nb = 0;
    while (!dn64 && cyc < 300) begin
      if (bsy64) nb++;
      tick();
      cyc++;
    end
  endtask

  task automatic wait8(output int cyc);
    cyc = 1;
    while (!dn8 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  int          cyc, nb, ndone, dcyc;
  logic [63:0] rres;

  initial begin
    reset = 1'b1;
    s64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;
    s8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
    repeat (3) tick();

    chk("rst_result", r64, 64'd0);
    chk("rst_zero", {63'd0, z64}, 64'd1);
    chk("rst_nzcv", {60'd0, n64, c64, v64, dn64}, 64'd0);
    chk("rst_busy_ready", {62'd0, bsy64, rdy64}, 64'd1);
    chk("rst8_result", {56'd0, r8}, 64'd0);
    reset = 1'b0;
    tick();

    go64(4'b0010, 64'd5, 64'd7);
    chk("add_done", {63'd0, dn64}, 64'd1);
    chk("add_busy", {63'd0, bsy64}, 64'd0);
    chk("add_result", r64, 64'd12);
    chk("add_zcv", {61'd0, z64, c64, v64}, 64'd0);
    tick();
    chk("add_done_pulse", {63'd0, dn64}, 64'd0);
    chk("add_result_held", r64, 64'd12);

    go64(4'b0110, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    chk("sub_result", r64, 64'd0);
    chk("sub_zero", {63'd0, z64}, 64'd1);
    chk("sub_carry", {63'd0, c64}, 64'd1);
    chk("sub_ovf", {63'd0, v64}, 64'd0);

    go64(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("addov_result", r64, 64'h8000_0000_0000_0000);
    chk("addov_neg", {63'd0, n64}, 64'd1);
    chk("addov_ovf", {63'd0, v64}, 64'd1);
    chk("addov_carry", {63'd0, c64}, 64'd0);

    go64(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait64(cyc, nb);
    chk("mul_latency", 64'(cyc), 64'd65);
    chk("mul_busy_cycles", 64'(nb), 64'd64);
    chk("mul_result", r64, 64'd1);
    chk("mul_ready_on_done", {63'd0, rdy64}, 64'd1);

    go64(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait64(cyc, nb);
    chk("umulh_latency", 64'(cyc), 64'd65);
    chk("umulh_result", r64, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("umulh_nc", {62'd0, n64, c64}, 64'd2);
    tick();
    chk("umulh_done_pulse", {63'd0, dn64}, 64'd0);

    go8(4'b1011, 8'hF9, 8'h02);
    wait8(cyc);
    chk("sdiv_latency", 64'(cyc), 64'd10);
    chk("sdiv_result", {56'd0, r8}, 64'h0FD);
    chk("sdiv_neg", {63'd0, n8}, 64'd1);
    tick();

    go8(4'b1011, 8'h80, 8'hFF);
    wait8(cyc);
    chk("sdiv_wrap_latency", 64'(cyc), 64'd10);
    chk("sdiv_wrap_result", {56'd0, r8}, 64'h080);
    chk("sdiv_wrap_ovf", {63'd0, v8}, 64'd0);
    tick();

    go8(4'b1010, 8'd9, 8'd0);
    wait8(cyc);
    chk("udiv0_latency", 64'(cyc), 64'd9);
    chk("udiv0_result", {56'd0, r8}, 64'd0);
    chk("udiv0_zero", {63'd0, z8}, 64'd1);
    tick();

    go64(4'b1010, 64'd100, 64'd7);
    ndone = 0; dcyc = 0; rres = '0;
    for (int k = 1; k <= 80; k++) begin
      if (dn64) begin
        ndone++;
        dcyc = k;
        rres = r64;
      end
      if (k == 3 || k == 20) begin
        s64 = 1'b1; op64 = 4'b0010; a64 = 64'd1; b64 = 64'd1;
      end else begin
        s64 = 1'b0; a64 = 64'($urandom); b64 = '0;
      end
      tick();
    end
    s64 = 1'b0;
    chk("hs_done_count", 64'(ndone), 64'd1);
    chk("hs_done_cycle", 64'(dcyc), 64'd65);
    chk("hs_result", rres, 64'd14);
    chk("hs_result_held", r64, 64'd14);

    go64(4'b1000, 64'd3, 64'd5);
    repeat (29) tick();
    chk("abort_busy_before", {62'd0, bsy64, rdy64}, 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_result", r64, 64'd0);
    chk("abort_zero", {63'd0, z64}, 64'd1);
    chk("abort_flags_done", {60'd0, n64, c64, v64, dn64}, 64'd0);
    chk("abort_busy_ready", {62'd0, bsy64, rdy64}, 64'd1);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      if (dn64) ndone++;
      tick();
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    go64(4'b0001, 64'hF0, 64'h0F);
    chk("orr_done", {63'd0, dn64}, 64'd1);
    chk("orr_result", r64, 64'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
